gcd_arbiter: RTL and testbench
==============================

Name: gcd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one GCD unit (datapath plus its controlpath) between N requesters.
- Accepts an operand pair from one requester and issues it to the GCD unit with a single-cycle input_available pulse.
- Takes the result with result_taken and returns it to the same requester over a valid/ready response handshake.
- Sits between the requester fabric and the single GCD instance; the GCD unit is not modified.

Parameters:
- N, 4, number of requesters (2..8).
- W, 16, operand and result width in bits.
- IW, 2, requester index width; must equal clog2(N).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  N  per-requester request valid.
- req_ready  output  N  per-requester accept; one-hot or zero.
- req_A  input  N*W  operand A; requester i occupies bits [i*W +: W].
- req_B  input  N*W  operand B; same packing as req_A.
- resp_valid  output  N  per-requester response valid; one-hot or zero.
- resp_ready  input  N  per-requester response accept.
- resp_data  output  W  GCD result, shared by all requesters, qualified by resp_valid.
- gcd_input_available  output  1  start pulse to the GCD unit.
- gcd_A  output  W  operand A to the GCD unit.
- gcd_B  output  W  operand B to the GCD unit.
- gcd_result_ready  input  1  GCD unit result valid.
- gcd_result  input  W  GCD unit result value.
- gcd_result_taken  output  1  result consumed; pulse to the GCD unit.
- busy  output  1  high in any state other than IDLE.
- grant_idx  output  IW  index of the current or last granted requester.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state = IDLE, rr_ptr = 0, grant_idx = 0;
  - opA = opB = 0, resp_data = 0;
  - req_ready, resp_valid, gcd_input_available, gcd_result_taken and busy all 0.
- Outputs are decoded from registered state only, except req_ready, which is combinational from state, req_valid and rr_ptr.
- State machine (4 states): IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Winner g = first index with req_valid set, searching rr_ptr, rr_ptr+1, ... and wrapping modulo N.
  - req_ready[g] = 1 in the same cycle; the handshake completes that cycle.
  - On the clock edge: opA <= req_A[g], opB <= req_B[g], grant_idx <= g, go to ISSUE.
  - If no req_valid is set, stay in IDLE with req_ready = 0.
- ISSUE: gcd_input_available = 1 for exactly one cycle, then go to BUSY.
- gcd_A and gcd_B drive opA and opB continuously. They stay stable from ISSUE through the end of RESP.
- BUSY:
  - Wait for gcd_result_ready.
  - When it is high: gcd_result_taken = 1 in that cycle, resp_data <= gcd_result, go to RESP.
  - gcd_result_ready is ignored in all states other than BUSY, and gcd_result_taken is never asserted elsewhere.
- RESP:
  - resp_valid[grant_idx] = 1, held with resp_data stable until resp_ready[grant_idx] is high.
  - On that handshake: rr_ptr <= (grant_idx + 1) mod N, go to IDLE.
  - resp_ready on other indices is ignored.
- Latency:
  - Request accept at cycle t; gcd_input_available at t+1.
  - If gcd_result_ready is first seen at cycle r, then resp_valid is asserted at r+1.
  - After the response handshake there is one IDLE cycle before the next accept. Minimum spacing between issues is GCD latency + 3 cycles.
- Only one operation is in flight at a time. A requester deasserting req_valid before it is granted is legal and is simply skipped. There is no ordering or starvation guarantee beyond round-robin: each requester waits at most N-1 grants.
- rr_ptr updates only on response completion, never on accept.
- Reset asserted mid-operation (ISSUE, BUSY or RESP):
  - The in-flight request is dropped with no response; the requester must reissue.
  - The GCD unit is reset from the same reset net.
- Index arithmetic is modulo N. For N not a power of two, an index wrapping past N-1 returns to 0.

Test Plan:
- Single request: N=4, W=16, requester 1 sends A=48, B=18; bench GCD model with 5-cycle latency.
  - Expected: req_ready[1] in the same cycle; one gcd_input_available pulse; gcd_result_taken for one cycle; resp_valid[1] with resp_data=6, held until resp_ready[1].
- All four request together (0:12/8, 1:21/14, 2:35/10, 3:9/6).
  - Expected grant order 0,1,2,3; results 4, 7, 5, 3, each on the matching resp_valid bit; rr_ptr ends at 0.
- Fairness: after requester 2 completes, requesters 0 and 3 are valid.
  - Expected: requester 3 is granted first, then 0.
- Backpressure: hold resp_ready[0] low for 10 cycles in RESP.
  - Expected: resp_valid[0] and resp_data stay stable; no gcd_input_available; req_ready stays 0 for pending requesters.
- Reset mid-BUSY: assert reset with gcd_result_ready still low.
  - Expected, immediately and asynchronously: all outputs 0, busy 0, no response for the dropped request.
  - After release, a new request on requester 2 (A=100, B=75) returns 25.
- Ignored result: pulse gcd_result_ready while in IDLE.
  - Expected: no gcd_result_taken, no resp_valid, state unchanged.

Source files
------------

// File: rtl/gcd_arbiter_if.sv
// Requester-side bus of the GCD arbiter: per-requester operand requests and
// per-requester responses sharing one result bus.
interface gcd_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 16
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_A;
    logic [N*W-1:0] req_B;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [W-1:0]   resp_data;

    modport master (
        output req_valid, req_A, req_B, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_A, req_B, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD unit between N requesters, issuing
// one operand pair at a time and routing the result back to its requester.
module gcd_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 16,
    parameter int unsigned IW = 2
) (
    input  logic          clk,
    input  logic          reset,
    gcd_arbiter_if.slave  bus,
    output logic          gcd_input_available,
    output logic [W-1:0]  gcd_A,
    output logic [W-1:0]  gcd_B,
    input  logic          gcd_result_ready,
    input  logic [W-1:0]  gcd_result,
    output logic          gcd_result_taken,
    output logic          busy,
    output logic [IW-1:0] grant_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] grant_q;
    logic [W-1:0]  op_a_q;
    logic [W-1:0]  op_b_q;
    logic [W-1:0]  resp_data_q;

    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic [N-1:0]  req_ready_c;
    logic [N-1:0]  resp_valid_c;

    // Scan from the farthest offset down so the entry closest to rr_ptr wins.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (bus.req_valid[IW'((int'(rr_ptr_q) + k) % int'(N))]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(rr_ptr_q) + k) % int'(N));
            end
        end
    end

    // Accept is gated by reset so no handshake can complete while held in reset.
    always_comb begin
        req_ready_c = '0;
        if (reset && (state_q == IDLE) && win_vld) begin
            req_ready_c[win_idx] = 1'b1;
        end
    end

    always_comb begin
        resp_valid_c = '0;
        if (state_q == RESP) begin
            resp_valid_c[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            resp_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        op_a_q  <= bus.req_A[win_idx*W +: W];
                        op_b_q  <= bus.req_B[win_idx*W +: W];
                        grant_q <= win_idx;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: state_q <= BUSY;
                BUSY: begin
                    if (gcd_result_ready) begin
                        resp_data_q <= gcd_result;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    // Pointer advances only on response completion.
                    if (bus.resp_ready[grant_q]) begin
                        rr_ptr_q <= IW'((int'(grant_q) + 1) % int'(N));
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready          = req_ready_c;
    assign bus.resp_valid         = resp_valid_c;
    assign bus.resp_data          = resp_data_q;
    assign gcd_input_available    = (state_q == ISSUE);
    assign gcd_result_taken       = (state_q == BUSY) && gcd_result_ready;
    assign gcd_A                  = op_a_q;
    assign gcd_B                  = op_b_q;
    assign busy                   = (state_q != IDLE);
    assign grant_idx              = grant_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a fixed-latency GCD unit model.
module tb_gcd_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned IW  = 2;
    localparam int          LAT = 5;

    logic          clk;
    logic          reset;
    logic          gcd_input_available;
    logic [W-1:0]  gcd_A;
    logic [W-1:0]  gcd_B;
    logic          gcd_result_ready;
    logic [W-1:0]  gcd_result;
    logic          gcd_result_taken;
    logic          busy;
    logic [IW-1:0] grant_idx;

    gcd_arbiter_if #(.N(N), .W(W)) bus ();

    gcd_arbiter #(.N(N), .W(W), .IW(IW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .gcd_input_available (gcd_input_available),
        .gcd_A               (gcd_A),
        .gcd_B               (gcd_B),
        .gcd_result_ready    (gcd_result_ready),
        .gcd_result          (gcd_result),
        .gcd_result_taken    (gcd_result_taken),
        .busy                (busy),
        .grant_idx           (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // GCD unit model: result appears LAT edges after the start pulse is sampled.
    function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    logic         gm_busy;
    int           gm_cnt;
    logic [W-1:0] gm_res;
    logic         gm_rdy;
    logic         inj_rdy;
    logic [W-1:0] inj_val;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            gm_busy <= 1'b0;
            gm_cnt  <= 0;
            gm_res  <= '0;
            gm_rdy  <= 1'b0;
        end else begin
            if (gcd_input_available) begin
                gm_busy <= 1'b1;
                gm_cnt  <= LAT;
                gm_res  <= gcd_fn(gcd_A, gcd_B);
            end else if (gm_busy && gm_cnt > 1) begin
                gm_cnt <= gm_cnt - 1;
            end else if (gm_busy) begin
                gm_busy <= 1'b0;
                gm_rdy  <= 1'b1;
            end
            if (gm_rdy && gcd_result_taken) gm_rdy <= 1'b0;
        end
    end

    assign gcd_result_ready = gm_rdy | inj_rdy;
    assign gcd_result       = gm_rdy ? gm_res : inj_val;

    typedef struct {
        logic [N-1:0]  rdy;
        logic          iss_first;
        logic [IW-1:0] gnt;
        int            issues;
        int            takes;
        int            lat;
        logic [N-1:0]  vld;
        logic [W-1:0]  data;
        bit            stable;
        logic [N-1:0]  end_vld;
        logic          end_busy;
    } obs_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_A[i*W +: W] = a;
        bus.req_B[i*W +: W] = b;
    endtask

    // Drives one transaction from accept to response handshake and records what it saw.
    task automatic txn(input logic [N-1:0] pend, input int hold, output obs_t o);
        o.issues = 0; o.takes = 0; o.lat = 0; o.stable = 1'b1;
        #1;
        o.rdy = bus.req_ready;
        tick();
        bus.req_valid = (bus.req_valid & ~o.rdy) | pend;
        o.iss_first = gcd_input_available;
        o.gnt = grant_idx;
        for (int c = 0; c < 40 && bus.resp_valid == '0; c++) begin
            if (gcd_input_available) o.issues++;
            if (gcd_result_taken) o.takes++;
            o.lat++;
            tick();
        end
        o.vld  = bus.resp_valid;
        o.data = bus.resp_data;
        bus.resp_ready = ~o.vld;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (bus.resp_valid !== o.vld || bus.resp_data !== o.data ||
                gcd_input_available !== 1'b0 || bus.req_ready !== '0) o.stable = 1'b0;
        end
        bus.resp_ready = o.vld;
        tick();
        bus.resp_ready = '0;
        o.end_vld  = bus.resp_valid;
        o.end_busy = busy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.req_valid = '1;
        tick(); tick();
        n_checks++;
        if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset req_ready: got %b want 0", bus.req_ready); end
        n_checks++;
        if (busy !== 1'b0 || gcd_input_available !== 1'b0 || gcd_result_taken !== 1'b0) begin
            n_fail++; $display("FAIL reset ctrl: busy=%b avail=%b taken=%b want 0", busy, gcd_input_available, gcd_result_taken);
        end
        n_checks++;
        if (bus.resp_valid !== '0 || bus.resp_data !== '0) begin
            n_fail++; $display("FAIL reset resp: valid=%b data=%0d want 0", bus.resp_valid, bus.resp_data);
        end
        n_checks++;
        if (grant_idx !== '0 || gcd_A !== '0 || gcd_B !== '0) begin
            n_fail++; $display("FAIL reset regs: grant=%0d A=%0d B=%0d want 0", grant_idx, gcd_A, gcd_B);
        end
        bus.req_valid = '0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_all_four();
        logic [W-1:0] exp_res [4];
        obs_t o;
        exp_res[0] = 4; exp_res[1] = 7; exp_res[2] = 5; exp_res[3] = 3;
        set_op(0, 12, 8); set_op(1, 21, 14); set_op(2, 35, 10); set_op(3, 9, 6);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            txn('0, 0, o);
            n_checks++;
            if (o.rdy !== N'(1 << i) || o.gnt !== IW'(i)) begin
                n_fail++; $display("FAIL all_four grant %0d: ready=%b grant=%0d", i, o.rdy, o.gnt);
            end
            n_checks++;
            if (o.vld !== N'(1 << i) || o.data !== exp_res[i]) begin
                n_fail++; $display("FAIL all_four resp %0d: valid=%b data=%0d want data %0d", i, o.vld, o.data, exp_res[i]);
            end
            n_checks++;
            if (o.issues !== 1 || o.takes !== 1 || o.end_vld !== '0 || o.end_busy !== 1'b0) begin
                n_fail++; $display("FAIL all_four pulses %0d: issues=%0d takes=%0d end_vld=%b end_busy=%b", i, o.issues, o.takes, o.end_vld, o.end_busy);
            end
        end
        // rr_ptr back at 0: requester 0 must beat requester 3.
        bus.req_valid = 4'b1001;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL all_four rr_ptr wrap: ready=%b want 0001", bus.req_ready); end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        obs_t o;
        set_op(1, 48, 18);
        bus.req_valid = 4'b0010;
        txn('0, 3, o);
        n_checks++;
        if (o.rdy !== 4'b0010 || o.iss_first !== 1'b1 || o.gnt !== 2'd1) begin
            n_fail++; $display("FAIL single accept: ready=%b avail=%b grant=%0d", o.rdy, o.iss_first, o.gnt);
        end
        n_checks++;
        if (o.issues !== 1 || o.takes !== 1 || o.lat !== LAT + 2) begin
            n_fail++; $display("FAIL single timing: issues=%0d takes=%0d lat=%0d want 1 1 %0d", o.issues, o.takes, o.lat, LAT + 2);
        end
        n_checks++;
        if (o.vld !== 4'b0010 || o.data !== 16'd6 || o.stable !== 1'b1) begin
            n_fail++; $display("FAIL single resp: valid=%b data=%0d stable=%0d want 0010 6 1", o.vld, o.data, o.stable);
        end
        n_checks++;
        if (o.end_vld !== '0 || o.end_busy !== 1'b0) begin
            n_fail++; $display("FAIL single close: valid=%b busy=%b want 0", o.end_vld, o.end_busy);
        end
    endtask

    task automatic test_fairness();
        obs_t o;
        set_op(2, 27, 18);
        bus.req_valid = 4'b0100;
        txn('0, 0, o);
        n_checks++;
        if (o.gnt !== 2'd2 || o.data !== 16'd9) begin
            n_fail++; $display("FAIL fairness first: grant=%0d data=%0d want 2 9", o.gnt, o.data);
        end
        set_op(0, 16, 24); set_op(3, 45, 30);
        bus.req_valid = 4'b1001;
        txn('0, 0, o);
        n_checks++;
        if (o.gnt !== 2'd3 || o.vld !== 4'b1000 || o.data !== 16'd15) begin
            n_fail++; $display("FAIL fairness second: grant=%0d valid=%b data=%0d want 3 1000 15", o.gnt, o.vld, o.data);
        end
        txn('0, 0, o);
        n_checks++;
        if (o.gnt !== 2'd0 || o.vld !== 4'b0001 || o.data !== 16'd8) begin
            n_fail++; $display("FAIL fairness third: grant=%0d valid=%b data=%0d want 0 0001 8", o.gnt, o.vld, o.data);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        set_op(0, 20, 8); set_op(2, 14, 21);
        bus.req_valid = 4'b0001;
        txn(4'b0100, 10, o);
        n_checks++;
        if (o.gnt !== 2'd0 || o.vld !== 4'b0001 || o.data !== 16'd4) begin
            n_fail++; $display("FAIL backpressure resp: grant=%0d valid=%b data=%0d want 0 0001 4", o.gnt, o.vld, o.data);
        end
        n_checks++;
        if (o.stable !== 1'b1) begin n_fail++; $display("FAIL backpressure hold: stable=%0d want 1", o.stable); end
        txn('0, 0, o);
        n_checks++;
        if (o.gnt !== 2'd2 || o.data !== 16'd7) begin
            n_fail++; $display("FAIL backpressure pending: grant=%0d data=%0d want 2 7", o.gnt, o.data);
        end
    endtask

    task automatic test_reset_mid_busy();
        obs_t o;
        int   seen;
        set_op(1, 30, 12);
        bus.req_valid = 4'b0010;
        tick(); tick();
        bus.req_valid = '0;
        tick();
        n_checks++;
        if (busy !== 1'b1 || gcd_result_ready !== 1'b0) begin
            n_fail++; $display("FAIL midbusy setup: busy=%b ready=%b want 1 0", busy, gcd_result_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || gcd_input_available !== 1'b0 || gcd_result_taken !== 1'b0 ||
            grant_idx !== '0 || gcd_A !== '0 || gcd_B !== '0) begin
            n_fail++; $display("FAIL midbusy async: busy=%b avail=%b taken=%b grant=%0d A=%0d B=%0d want 0",
                               busy, gcd_input_available, gcd_result_taken, grant_idx, gcd_A, gcd_B);
        end
        n_checks++;
        if (bus.resp_valid !== '0 || bus.resp_data !== '0 || bus.req_ready !== '0) begin
            n_fail++; $display("FAIL midbusy resp: valid=%b data=%0d ready=%b want 0", bus.resp_valid, bus.resp_data, bus.req_ready);
        end
        tick(); tick();
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.resp_valid !== '0 || gcd_input_available !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midbusy dropped: activity cycles=%0d want 0", seen); end
        set_op(2, 100, 75);
        bus.req_valid = 4'b0100;
        txn('0, 0, o);
        n_checks++;
        if (o.gnt !== 2'd2 || o.vld !== 4'b0100 || o.data !== 16'd25) begin
            n_fail++; $display("FAIL midbusy new req: grant=%0d valid=%b data=%0d want 2 0100 25", o.gnt, o.vld, o.data);
        end
    endtask

    task automatic test_ignored_result();
        inj_val = 16'd99;
        inj_rdy = 1'b1;
        #1;
        n_checks++;
        if (gcd_result_taken !== 1'b0) begin n_fail++; $display("FAIL ignored taken: got %b want 0", gcd_result_taken); end
        tick();
        inj_rdy = 1'b0;
        n_checks++;
        if (bus.resp_valid !== '0 || busy !== 1'b0 || bus.resp_data !== 16'd25 || grant_idx !== 2'd2) begin
            n_fail++; $display("FAIL ignored state: valid=%b busy=%b data=%0d grant=%0d want 0 0 25 2",
                               bus.resp_valid, busy, bus.resp_data, grant_idx);
        end
    endtask

    initial begin
        reset          = 1'b0;
        inj_rdy        = 1'b0;
        inj_val        = '0;
        bus.req_valid  = '0;
        bus.req_A      = '0;
        bus.req_B      = '0;
        bus.resp_ready = '0;
        test_reset();
        test_all_four();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid_busy();
        test_ignored_result();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
